// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that consumes operands LSB-first,
// DIGIT bits per clock, behind valid/ready handshakes on input and output.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NDIG = WIDTH / DIGIT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [DIGIT-1:0] slice_sum;
    logic             slice_cout;
    logic             msb_cin;
    logic [WIDTH-1:0] res_next;
    logic             last;
    logic             accept;

    assign accept = (state == IDLE) && in_valid;

    // Ripple chain of full-adder cells; msb_cin ends up as the carry into the
    // top cell, which on the final digit is the carry into the word MSB.
    always_comb begin : slice
        logic c;
        c         = carry;
        slice_sum = '0;
        msb_cin   = 1'b0;
        for (int i = 0; i < DIGIT; i++) begin
            msb_cin      = c;
            slice_sum[i] = a_reg[i] ^ b_reg[i] ^ c;
            c            = (a_reg[i] & b_reg[i]) | (c & (a_reg[i] ^ b_reg[i]));
        end
        slice_cout = c;
    end

    generate
        if (NDIG == 1) begin : g_single
            assign res_next = slice_sum;
            assign last     = 1'b1;
        end else begin : g_multi
            localparam int CW = $clog2(NDIG);

            logic [CW-1:0]          count;
            logic [WIDTH-DIGIT-1:0] res_reg;

            // Earlier digits accumulate here; the final digit is appended
            // combinationally so the full word loads into sum in one edge.
            assign res_next = {slice_sum, res_reg};
            assign last     = (count == CW'(NDIG - 1));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count   <= '0;
                    res_reg <= '0;
                end else if (accept) begin
                    count   <= '0;
                    res_reg <= '0;
                end else if (busy) begin
                    res_reg <= res_next[WIDTH-1:DIGIT];
                    if (!last) begin
                        count <= count + CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Subtraction is a + ~b + ~borrow, folded in at capture.
                    if (accept) begin
                        a_reg    <= a;
                        b_reg    <= sub ? ~b : b;
                        carry    <= cin ^ sub;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= slice_cout;
                    if (last) begin
                        sum       <= res_next;
                        cout      <= slice_cout;
                        ovf       <= msb_cin ^ slice_cout;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks five serial_adder configurations (8/1, 8/4, 8/8, 3/1, 3/3)
// against an arithmetic reference model, a vector table and hand-written sequences.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic [4:0]      in_valid_v, in_ready_v, cin_v, sub_v, out_valid_v;
    logic [4:0]      out_ready_v, cout_v, ovf_v, busy_v;
    logic [4:0][7:0] a_v, b_v;
    logic [2:0][7:0] s8;
    logic [1:0][2:0] s3;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .sum(s8[0]),
        .cout(cout_v[0]), .ovf(ovf_v[0]), .busy(busy_v[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .sum(s8[1]),
        .cout(cout_v[1]), .ovf(ovf_v[1]), .busy(busy_v[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .sum(s8[2]),
        .cout(cout_v[2]), .ovf(ovf_v[2]), .busy(busy_v[2]));

    serial_adder #(.WIDTH(3), .DIGIT(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3][2:0]), .b(b_v[3][2:0]), .cin(cin_v[3]), .sub(sub_v[3]),
        .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]), .sum(s3[0]),
        .cout(cout_v[3]), .ovf(ovf_v[3]), .busy(busy_v[3]));

    serial_adder #(.WIDTH(3), .DIGIT(3)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[4]), .in_ready(in_ready_v[4]),
        .a(a_v[4][2:0]), .b(b_v[4][2:0]), .cin(cin_v[4]), .sub(sub_v[4]),
        .out_valid(out_valid_v[4]), .out_ready(out_ready_v[4]), .sum(s3[1]),
        .cout(cout_v[4]), .ovf(ovf_v[4]), .busy(busy_v[4]));

    function automatic int ndig(input int k);
        case (k)
            0:       return 8;
            1:       return 2;
            3:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int width_of(input int k);
        return (k < 3) ? 8 : 3;
    endfunction

    function automatic logic [7:0] get_sum(input int k);
        if (k < 3) return s8[k];
        return {5'b0, s3[k-3]};
    endfunction

    // Reference: plain integer arithmetic on the w-bit operands.
    function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic sub,
                                  output logic [7:0] s, output logic co, output logic ov);
        int mask, half, av, bv, c, full, sa, sb, ss;
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        av   = int'(a) & mask;
        bv   = sub ? ((~int'(b)) & mask) : (int'(b) & mask);
        c    = (cin ^ sub) ? 1 : 0;
        full = av + bv + c;
        s    = 8'(full & mask);
        co   = ((full >> w) & 1) != 0;
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        ss   = sa + sb + c;
        ov   = (ss >= half) || (ss < -half);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one operation to instance k and returns once out_valid is seen.
    task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub, input logic rdy,
                                 output logic [7:0] s, output logic co, output logic ov,
                                 output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready_v[k]) checkOutput($sformatf("in_ready_timeout_u%0d", k), 32'(in_ready_v[k]), 32'd1);
        a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub;
        in_valid_v[k]  = 1'b1;
        out_ready_v[k] = rdy;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
        cin_v[k] = 1'($urandom); sub_v[k] = 1'($urandom);
        lat = 0;
        while (!out_valid_v[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid_v[k]) checkOutput($sformatf("out_valid_timeout_u%0d", k), 32'(out_valid_v[k]), 32'd1);
        s  = get_sum(k);
        co = cout_v[k];
        ov = ovf_v[k];
    endtask

    task automatic runAndCheck(input int k, input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sub,
                               input logic [7:0] es, input logic eco, input logic eov);
        logic [7:0] s;
        logic       co, ov;
        int         lat;
        applyStimulus(k, a, b, cin, sub, 1'b1, s, co, ov, lat);
        checkOutput($sformatf("%s_u%0d_sum a=%0h b=%0h c=%0b s=%0b", tag, k, a, b, cin, sub), 32'(s), 32'(es));
        checkOutput($sformatf("%s_u%0d_cout", tag, k), 32'(co), 32'(eco));
        checkOutput($sformatf("%s_u%0d_ovf", tag, k), 32'(ov), 32'(eov));
        checkOutput($sformatf("%s_u%0d_latency", tag, k), 32'(lat), 32'(ndig(k)));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] es, s;
        logic       eco, eov, co, ov;
        int         lat;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        in_valid_v = '0; out_ready_v = '1; cin_v = '0; sub_v = '0;
        a_v = '0; b_v = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("reset_in_ready_u%0d", k), 32'(in_ready_v[k]), 32'd1);
            checkOutput($sformatf("reset_out_valid_u%0d", k), 32'(out_valid_v[k]), 32'd0);
            checkOutput($sformatf("reset_busy_u%0d", k), 32'(busy_v[k]), 32'd0);
            checkOutput($sformatf("reset_sum_u%0d", k), 32'(get_sum(k)), 32'd0);
            checkOutput($sformatf("reset_cout_ovf_u%0d", k), 32'({cout_v[k], ovf_v[k]}), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] vector table on 8-bit configurations");
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) begin
                runAndCheck(k, "table", vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                            vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            end
        end

        $display("[TB] in_valid pulses during RUN/DONE and output backpressure");
        @(negedge clk);
        while (!in_ready_v[0]) @(negedge clk);
        a_v[0] = 8'h10; b_v[0] = 8'h20; cin_v[0] = 1'b0; sub_v[0] = 1'b1;
        in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!out_valid_v[0] && lat < 100) begin
            in_valid_v[0] = 1'b1;
            a_v[0] = 8'($urandom); b_v[0] = 8'($urandom); sub_v[0] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        checkOutput("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            in_valid_v[0] = 1'($urandom);
            a_v[0] = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp_out_valid_%0d", i), 32'(out_valid_v[0]), 32'd1);
            checkOutput($sformatf("bp_in_ready_%0d", i), 32'(in_ready_v[0]), 32'd0);
            checkOutput($sformatf("bp_busy_%0d", i), 32'(busy_v[0]), 32'd0);
            checkOutput($sformatf("bp_sum_%0d", i), 32'(s8[0]), 32'hF0);
            checkOutput($sformatf("bp_cout_ovf_%0d", i), 32'({cout_v[0], ovf_v[0]}), 32'd0);
        end
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bp_release_out_valid", 32'(out_valid_v[0]), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready_v[0]), 32'd1);
        checkOutput("bp_hold_sum", 32'(s8[0]), 32'hF0);

        $display("[TB] asynchronous reset in the middle of RUN");
        a_v[0] = 8'hFF; b_v[0] = 8'hFF; cin_v[0] = 1'b1; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_in_ready", 32'(in_ready_v[0]), 32'd1);
        checkOutput("midrun_out_valid", 32'(out_valid_v[0]), 32'd0);
        checkOutput("midrun_busy", 32'(busy_v[0]), 32'd0);
        checkOutput("midrun_sum", 32'(s8[0]), 32'd0);
        checkOutput("midrun_cout_ovf", 32'({cout_v[0], ovf_v[0]}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runAndCheck(0, "after_reset", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("[TB] randomized operations against reference model");
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 25; i++) begin
                logic [7:0] ra, rb;
                logic       rc, rs;
                ra = 8'($urandom); rb = 8'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
                model(width_of(k), ra, rb, rc, rs, es, eco, eov);
                runAndCheck(k, "rand", ra, rb, rc, rs, es, eco, eov);
            end
        end

        $display("[TB] exhaustive 3-bit operand sweep");
        for (int k = 3; k < 5; k++) begin
            for (int v = 0; v < 256; v++) begin
                logic [7:0] ea, eb;
                logic       ec, esub;
                ea   = 8'(v & 7);
                eb   = 8'((v >> 3) & 7);
                ec   = 1'((v >> 6) & 1);
                esub = 1'((v >> 7) & 1);
                model(3, ea, eb, ec, esub, es, eco, eov);
                applyStimulus(k, ea, eb, ec, esub, 1'b1, s, co, ov, lat);
                checkOutput($sformatf("exh_u%0d_v%0d_sum", k, v), 32'(s), 32'(es));
                checkOutput($sformatf("exh_u%0d_v%0d_cout", k, v), 32'(co), 32'(eco));
                checkOutput($sformatf("exh_u%0d_v%0d_ovf", k, v), 32'(ov), 32'(eov));
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
